wb_traffic_gen: RTL and testbench

Wishbone B4 bus master that drives the SDRAM controller's application port as an upstream traffic source. After sdr_init_done, it writes a programmed number of incrementing bursts with a deterministic data pattern. It then reads the same region back, compares every returned word and reports error count, first failing address and a timeout flag. It can be synthesised as a self-test engine and instanced in the testbench as a stimulus generator.

---
 rtl/wb_tg_pkg.sv | 20 ++
 rtl/wb_tg_checker.sv | 59 +++++
 rtl/wb_traffic_gen.sv | 220 ++++++++++++++++++++++
 tb/tb_wb_traffic_gen.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_tg_pkg.sv
// Shared types and constants for the Wishbone traffic generator.
package wb_tg_pkg;

    // Run sequencing: write bursts, then read the same region back, then finish.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_INIT,
        ST_WR,
        ST_WR_GAP,
        ST_RD,
        ST_RD_GAP,
        ST_FIN
    } tg_state_t;

    // Wishbone B4 cycle type identifiers
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_tg_checker.sv
// Read-back checker: compares each acknowledged read word with the expected
// pattern, keeps a saturating mismatch count and latches the first bad address.
module wb_tg_checker
    import wb_tg_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          rd_stb,
    input  logic [DW-1:0] rd_data,
    input  logic [DW-1:0] exp_data,
    input  logic [AW-1:0] rd_adr,
    output logic [15:0]   err_cnt,
    output logic [AW-1:0] first_err_adr
);

    localparam int NBYTES = DW / 8;

    logic [NBYTES-1:0] byte_diff;
    logic              mismatch;
    logic [15:0]       err_cnt_reg;
    logic [AW-1:0]     first_err_adr_reg;

    // Byte-lane compare, reduced to a single mismatch flag
    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_lane
            assign byte_diff[gi] = (rd_data[gi*8 +: 8] != exp_data[gi*8 +: 8]);
        end
    endgenerate

    assign mismatch = rd_stb && (|byte_diff);

    // Error statistics: cleared by an accepted start, updated on bad read words
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_reg       <= '0;
            first_err_adr_reg <= '0;
        end else if (clr) begin
            err_cnt_reg       <= '0;
            first_err_adr_reg <= '0;
        end else if (mismatch) begin
            if (err_cnt_reg != 16'hFFFF) begin
                err_cnt_reg <= err_cnt_reg + 16'd1;
            end
            // The count never returns to zero within a run, so zero marks the first miss
            if (err_cnt_reg == 16'd0) begin
                first_err_adr_reg <= rd_adr;
            end
        end
    end

    assign err_cnt       = err_cnt_reg;
    assign first_err_adr = first_err_adr_reg;

endmodule

// File: rtl/wb_traffic_gen.sv
// Wishbone B4 burst master: writes an incrementing pattern over a programmed
// region after SDRAM init, reads it back and reports mismatches and timeouts.
module wb_traffic_gen
    import wb_tg_pkg::*;
#(
    parameter int          DW   = 32,
    parameter int          AW   = 32,
    parameter int          BL_W = 5,
    parameter int          NB_W = 8,
    parameter int          TMO  = 255,
    parameter logic [31:0] SEED = 32'hA5A5_0000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start,
    input  logic              sdr_init_done,
    input  logic [AW-1:0]     cfg_base,
    input  logic [BL_W-1:0]   cfg_blen,
    input  logic [NB_W-1:0]   cfg_nburst,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [AW-1:0]     wb_adr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [DW-1:0]     wb_dat_i,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [15:0]       err_cnt,
    output logic [AW-1:0]     first_err_adr
);

    localparam int            NSEL     = DW / 8;
    localparam int            TW       = (TMO > 1) ? $clog2(TMO + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);
    localparam logic [DW-1:0] SEED_W   = SEED[DW-1:0];
    localparam logic [AW-1:0] ADR_STEP = AW'(NSEL);

    tg_state_t       state_reg, state_next;
    logic [AW-1:0]   adr_reg, adr_next;
    logic [AW-1:0]   base_reg, base_next;
    logic [BL_W-1:0] last_beat_reg, last_beat_next;    // index of final beat in a burst
    logic [NB_W-1:0] last_burst_reg, last_burst_next;  // index of final burst in a phase
    logic [BL_W-1:0] beat_reg, beat_next;
    logic [NB_W-1:0] burst_reg, burst_next;
    logic [DW-1:0]   pat_reg, pat_next;
    logic [TW-1:0]   tmo_reg, tmo_next;
    logic            timeout_reg, timeout_next;
    logic            done_reg, done_next;

    logic            last_beat;
    logic            last_burst;
    logic            cyc_int;
    logic            start_accept;
    logic            rd_stb;

    assign last_beat  = (beat_reg == last_beat_reg);
    assign last_burst = (burst_reg == last_burst_reg);

    // State and datapath registers; reset drops the bus cycle immediately
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg      <= ST_IDLE;
            adr_reg        <= '0;
            base_reg       <= '0;
            last_beat_reg  <= '0;
            last_burst_reg <= '0;
            beat_reg       <= '0;
            burst_reg      <= '0;
            pat_reg        <= '0;
            tmo_reg        <= '0;
            timeout_reg    <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            adr_reg        <= adr_next;
            base_reg       <= base_next;
            last_beat_reg  <= last_beat_next;
            last_burst_reg <= last_burst_next;
            beat_reg       <= beat_next;
            burst_reg      <= burst_next;
            pat_reg        <= pat_next;
            tmo_reg        <= tmo_next;
            timeout_reg    <= timeout_next;
            done_reg       <= done_next;
        end
    end

    // Next-state, beat bookkeeping and bus outputs
    always_comb begin
        state_next      = state_reg;
        adr_next        = adr_reg;
        base_next       = base_reg;
        last_beat_next  = last_beat_reg;
        last_burst_next = last_burst_reg;
        beat_next       = beat_reg;
        burst_next      = burst_reg;
        pat_next        = pat_reg;
        tmo_next        = tmo_reg;
        timeout_next    = timeout_reg;
        done_next       = 1'b0;
        start_accept    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    start_accept    = 1'b1;
                    base_next       = cfg_base;
                    adr_next        = cfg_base;
                    last_beat_next  = (cfg_blen == '0) ? '0 : cfg_blen - BL_W'(1);
                    last_burst_next = cfg_nburst - NB_W'(1);
                    beat_next       = '0;
                    burst_next      = '0;
                    pat_next        = SEED_W;
                    tmo_next        = '0;
                    timeout_next    = 1'b0;
                    if (cfg_nburst == '0) begin
                        state_next = ST_FIN;
                    end else if (sdr_init_done) begin
                        state_next = ST_WR;
                    end else begin
                        state_next = ST_WAIT_INIT;
                    end
                end
            end
            ST_WAIT_INIT: begin
                if (sdr_init_done) begin
                    state_next = ST_WR;
                end
            end
            ST_WR, ST_RD: begin
                if (wb_ack_i) begin
                    tmo_next = '0;
                    adr_next = adr_reg + ADR_STEP;
                    pat_next = pat_reg + DW'(1);
                    if (last_beat) begin
                        beat_next = '0;
                        if (last_burst) begin
                            // Phase complete: rewind to the region start for read-back
                            burst_next = '0;
                            adr_next   = base_reg;
                            pat_next   = SEED_W;
                            state_next = (state_reg == ST_WR) ? ST_WR_GAP : ST_FIN;
                        end else begin
                            burst_next = burst_reg + NB_W'(1);
                            state_next = (state_reg == ST_WR) ? ST_WR_GAP : ST_RD_GAP;
                        end
                    end else begin
                        beat_next = beat_reg + BL_W'(1);
                    end
                end else if (tmo_reg == TMO_LAST) begin
                    timeout_next = 1'b1;
                    state_next   = ST_FIN;
                end else begin
                    tmo_next = tmo_reg + TW'(1);
                end
            end
            ST_WR_GAP: begin
                // Burst counter is rewound only after the final write burst
                state_next = (burst_reg == '0) ? ST_RD : ST_WR;
            end
            ST_RD_GAP: begin
                state_next = ST_RD;
            end
            ST_FIN: begin
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        cyc_int  = (state_reg == ST_WR) || (state_reg == ST_RD);
        wb_cyc_o = cyc_int;
        wb_stb_o = cyc_int;
        wb_we_o  = (state_reg == ST_WR);
        wb_adr_o = cyc_int ? adr_reg : '0;
        wb_dat_o = (state_reg == ST_WR) ? pat_reg : '0;
        if (!cyc_int) begin
            wb_cti_o = CTI_CLASSIC;
        end else if (last_beat) begin
            wb_cti_o = CTI_EOB;
        end else begin
            wb_cti_o = CTI_INCR;
        end
        rd_stb = (state_reg == ST_RD) && wb_ack_i;
    end

    // Full-word transfers only; selects follow the bus cycle
    genvar gi;
    generate
        for (gi = 0; gi < NSEL; gi++) begin : g_sel
            assign wb_sel_o[gi] = cyc_int;
        end
    endgenerate

    assign busy    = (state_reg != ST_IDLE);
    assign done    = done_reg;
    assign timeout = timeout_reg;

    wb_tg_checker #(
        .DW (DW),
        .AW (AW)
    ) u_checker (
        .clk           (wb_clk_i),
        .rst           (wb_rst_i),
        .clr           (start_accept),
        .rd_stb        (rd_stb),
        .rd_data       (wb_dat_i),
        .exp_data      (pat_reg),
        .rd_adr        (adr_reg),
        .err_cnt       (err_cnt),
        .first_err_adr (first_err_adr)
    );

endmodule

// File: tb/tb_wb_traffic_gen.sv
// Self-checking bench for wb_traffic_gen: a Wishbone slave with random wait
// states, stray acks and read corruption, checked against a transaction list.
module tb_wb_traffic_gen;

    localparam int          DW   = 32;
    localparam int          AW   = 32;
    localparam int          BL_W = 5;
    localparam int          NB_W = 8;
    localparam int          TMO  = 255;
    localparam logic [31:0] SEED = 32'hA5A5_0000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              sdr_init_done = 1'b0;
    logic [AW-1:0]     cfg_base = '0;
    logic [BL_W-1:0]   cfg_blen = '0;
    logic [NB_W-1:0]   cfg_nburst = '0;
    logic              wb_cyc_o, wb_stb_o, wb_we_o;
    logic [AW-1:0]     wb_adr_o;
    logic [DW-1:0]     wb_dat_o;
    logic [DW/8-1:0]   wb_sel_o;
    logic [2:0]        wb_cti_o;
    logic              wb_ack_i = 1'b0;
    logic [DW-1:0]     wb_dat_i = '0;
    logic              busy, done, timeout;
    logic [15:0]       err_cnt;
    logic [AW-1:0]     first_err_adr;

    always #5 clk = ~clk;

    wb_traffic_gen #(
        .DW (DW), .AW (AW), .BL_W (BL_W), .NB_W (NB_W), .TMO (TMO), .SEED (SEED)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .start         (start),
        .sdr_init_done (sdr_init_done),
        .cfg_base      (cfg_base),
        .cfg_blen      (cfg_blen),
        .cfg_nburst    (cfg_nburst),
        .wb_cyc_o      (wb_cyc_o),
        .wb_stb_o      (wb_stb_o),
        .wb_we_o       (wb_we_o),
        .wb_adr_o      (wb_adr_o),
        .wb_dat_o      (wb_dat_o),
        .wb_sel_o      (wb_sel_o),
        .wb_cti_o      (wb_cti_o),
        .wb_ack_i      (wb_ack_i),
        .wb_dat_i      (wb_dat_i),
        .busy          (busy),
        .done          (done),
        .timeout       (timeout),
        .err_cnt       (err_cnt),
        .first_err_adr (first_err_adr)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %0s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_cyc_stb"}, 64'({wb_cyc_o, wb_stb_o}), 64'd0);
        check_val({tag, "_bus"}, 64'({wb_we_o, wb_cti_o, wb_sel_o, wb_adr_o}), 64'd0);
        check_val({tag, "_dat"}, 64'(wb_dat_o), 64'd0);
        check_val({tag, "_status"}, 64'({busy, done, timeout, err_cnt}), 64'd0);
        check_val({tag, "_first_err"}, 64'(first_err_adr), 64'd0);
    endtask

    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [2:0]  cti;
        int          k;
    } beat_t;

    // One run: build the expected transaction list from the configuration,
    // act as the slave, and compare everything the master does against it.
    task automatic run_test(input logic [31:0] base, input logic [4:0] blen, input logic [7:0] nburst,
                            input int init_delay, input int max_wait, input logic [63:0] corrupt,
                            input int hang_beat, input int abort_beat);
        beat_t       exp_q[$];
        beat_t       e;
        int          bl, words, nacks, held, held_hang, wait_left, done_k, first_stb_k;
        int          idle_run, exp_err, cyc_before_init, cyc_total, exp_acks;
        bit          active, seen_beat, done_seen, aborted, expect_cyc, init_was, bad;
        logic [31:0] exp_first, cur_adr;

        bl = (blen == 0) ? 1 : int'(blen);
        words = bl * int'(nburst);
        exp_err = 0;
        exp_first = '0;
        for (int ph = 0; ph < 2; ph++) begin
            for (int w = 0; w < words; w++) begin
                e.we  = (ph == 0);
                e.k   = w;
                e.adr = base + 32'(4 * w);
                e.dat = SEED + 32'(w);
                e.cti = ((w % bl) == bl - 1) ? 3'b111 : 3'b010;
                exp_q.push_back(e);
                if (ph == 1 && w < 64 && corrupt[w]) begin
                    if (exp_err == 0) exp_first = e.adr;
                    exp_err++;
                end
            end
        end
        exp_acks = 2 * words;
        if (hang_beat >= 0) begin
            exp_err = 0;
            exp_first = '0;
            exp_acks = hang_beat;
        end

        nacks = 0; held = 0; held_hang = 0; wait_left = 0; done_k = 0; first_stb_k = 0;
        idle_run = 0; cyc_before_init = 0; cyc_total = 0;
        active = 0; seen_beat = 0; done_seen = 0; aborted = 0; expect_cyc = 0;
        cur_adr = '0;

        @(negedge clk);
        cfg_base = base;
        cfg_blen = blen;
        cfg_nburst = nburst;
        sdr_init_done = (init_delay == 0);
        start = 1'b1;

        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk);
            init_was = sdr_init_done;
            if (expect_cyc) check_val("burst_contig", 64'(wb_cyc_o), 64'd1);
            expect_cyc = 0;
            if (!init_was && wb_cyc_o) cyc_before_init++;
            if (k == 1) begin
                check_val("busy_after_start", 64'(busy), 64'd1);
                check_val("start_clr_timeout", 64'(timeout), 64'd0);
                check_val("start_clr_err", 64'({err_cnt, first_err_adr}), 64'd0);
            end
            if (done) begin
                done_seen = 1;
                done_k = k;
                check_val("busy_at_done", 64'(busy), 64'd0);
                break;
            end
            if (wb_cyc_o && wb_stb_o) begin
                cyc_total++;
                if (first_stb_k == 0) first_stb_k = k;
                if (seen_beat && idle_run > 0) check_val("gap_len", 64'(idle_run), 64'd1);
                idle_run = 0;
                seen_beat = 1;
                if (!active) begin
                    active = 1;
                    held = 0;
                    cur_adr = wb_adr_o;
                    wait_left = (nacks == hang_beat) ? 1000000 : int'($urandom_range(0, max_wait));
                end else begin
                    check_val("adr_stable", 64'(wb_adr_o), 64'(cur_adr));
                end
                held++;
                if (abort_beat >= 0 && nacks == abort_beat) begin
                    rst = 1'b1;
                    #1;
                    check_idle("rst_async");
                    aborted = 1;
                    break;
                end
                if (wait_left == 0) begin
                    bad = (exp_q.size() == 0);
                    check_val("extra_beat", 64'(bad), 64'd0);
                    if (!bad) begin
                        e = exp_q.pop_front();
                        wb_ack_i = 1'b1;
                        wb_dat_i = e.we ? $urandom : (e.dat ^ ((e.k < 64 && corrupt[e.k]) ? 32'h100 : 32'h0));
                        check_val("beat_we", 64'(wb_we_o), 64'(e.we));
                        check_val("beat_adr", 64'(wb_adr_o), 64'(e.adr));
                        check_val("beat_cti", 64'(wb_cti_o), 64'(e.cti));
                        check_val("beat_sel", 64'(wb_sel_o), 64'hF);
                        if (e.we) check_val("beat_dat", 64'(wb_dat_o), 64'(e.dat));
                        $display("txn %0s adr=%08h dat=%08h cti=%03b", e.we ? "WR" : "RD",
                                 wb_adr_o, e.we ? wb_dat_o : wb_dat_i, wb_cti_o);
                        expect_cyc = (e.cti == 3'b010);
                    end
                    nacks++;
                    active = 0;
                end else begin
                    wait_left--;
                    wb_ack_i = 1'b0;
                    wb_dat_i = $urandom;
                end
            end else begin
                if (active) held_hang = held;
                active = 0;
                if (seen_beat) idle_run++;
                wb_ack_i = (max_wait > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                wb_dat_i = $urandom;
            end
            if (k == 1) start = 1'b0;
            if (k == 2) begin
                cfg_base = $urandom;
                cfg_blen = 5'($urandom);
                cfg_nburst = 8'($urandom);
            end
            if (k == 3 && nburst != 0) start = 1'b1;
            if (k == 4) start = 1'b0;
            if (k >= init_delay) sdr_init_done = 1'b1;
        end

        wb_ack_i = 1'b0;
        start = 1'b0;
        if (aborted) begin
            @(negedge clk);
            check_idle("rst_hold");
            rst = 1'b0;
        end else begin
            check_val("done_seen", 64'(done_seen), 64'd1);
            check_val("beat_count", 64'(nacks), 64'(exp_acks));
            check_val("timeout", 64'(timeout), 64'(hang_beat >= 0));
            check_val("err_cnt", 64'(err_cnt), 64'(exp_err));
            check_val("first_err_adr", 64'(first_err_adr), 64'(exp_first));
            if (hang_beat >= 0) check_val("stb_held", 64'(held_hang), 64'(TMO));
            if (nburst == 0) begin
                check_val("done_latency", 64'(done_k), 64'd2);
                check_val("no_cyc", 64'(cyc_total), 64'd0);
            end else if (init_delay == 0) begin
                check_val("first_stb_latency", 64'(first_stb_k), 64'd1);
            end else begin
                check_val("cyc_before_init", 64'(cyc_before_init), 64'd0);
            end
            @(negedge clk);
            check_val("done_pulse_width", 64'(done), 64'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        // Basic write/read-back, two bursts of four
        run_test(32'h100, 5'd4, 8'd2, 0, 0, 64'd0, -1, -1);
        // Read words 5 and 7 corrupted
        run_test(32'h100, 5'd4, 8'd2, 0, 0, 64'hA0, -1, -1);
        // Zero burst length behaves as single-word bursts
        run_test(32'h200, 5'd0, 8'd1, 0, 0, 64'd0, -1, -1);
        // No bursts: immediate completion
        run_test(32'h300, 5'd4, 8'd0, 0, 0, 64'd0, -1, -1);
        // Third write beat never acknowledged
        run_test(32'h100, 5'd4, 8'd2, 0, 0, 64'd0, 2, -1);
        // Next run clears the timeout; controller still initialising at start
        run_test(32'h100, 5'd4, 8'd2, 3, 0, 64'd0, -1, -1);
        // Reset in the middle of a write burst, then a clean run
        run_test(32'h100, 5'd4, 8'd2, 0, 0, 64'd0, -1, 3);
        run_test(32'h100, 5'd4, 8'd2, 0, 0, 64'd0, -1, -1);
        // Address wrap across the top of the address space
        run_test(32'hFFFF_FFF8, 5'd3, 8'd2, 0, 1, 64'h10, -1, -1);

        for (int r = 0; r < 6; r++) begin
            run_test($urandom & 32'hFFFF_FFFC, 5'($urandom_range(0, 6)), 8'($urandom_range(1, 4)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                     {$urandom & $urandom, $urandom & $urandom}, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=0x0 exp=0x1");
        $fatal(1, "bench watchdog expired");
    end

endmodule
